// File: rtl/detag_cfg_sequencer_if.sv
// AXI-Stream beat bundle between parser, sequencer and detagger.
// The master drives the beat; the slave drives tready back.
interface detag_cfg_sequencer_if #(
    parameter int AXIS_BUS_WIDTH = 64
) ();
    logic [AXIS_BUS_WIDTH-1:0]   tdata;
    logic [AXIS_BUS_WIDTH/8-1:0] tkeep;
    logic                        tlast;
    logic                        tvalid;
    logic                        tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/detag_cfg_sequencer.sv
// Gates packets into the detagger and swaps tag_mode only when it is empty.
// Freezes per-packet side channels at SOP and bounds packets in flight.
module detag_cfg_sequencer #(
    parameter int AXIS_BUS_WIDTH     = 64,
    parameter int AXIS_ID_WIDTH      = 4,
    parameter int NUM_TAG_SIZES_LOG2 = 2,
    parameter int MAX_INFLIGHT       = 4,
    parameter int RESET_TAG_MODE     = 0,
    localparam int NUM_BUS_BYTES     = AXIS_BUS_WIDTH / 8,
    localparam int NUM_AXIS_ID       = 2 ** AXIS_ID_WIDTH,
    localparam int CNT_W             = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    detag_cfg_sequencer_if.slave          axis_in,
    detag_cfg_sequencer_if.master         axis_out,
    input  logic [NUM_AXIS_ID-1:0]        route_mask_in,
    input  logic                          cus_tag_present_in,
    output logic [NUM_AXIS_ID-1:0]        route_mask_out,
    output logic                          cus_tag_present_out,
    input  logic                          det_out_tvalid,
    input  logic                          det_out_tready,
    input  logic                          det_out_tlast,
    input  logic [NUM_TAG_SIZES_LOG2-1:0] cfg_tag_mode,
    input  logic                          cfg_wr,
    output logic                          cfg_ack,
    output logic                          cfg_busy,
    output logic [NUM_TAG_SIZES_LOG2-1:0] tag_mode,
    output logic [CNT_W-1:0]              inflight_count
);

    typedef enum logic [1:0] {
        IDLE,
        PKT,
        DRAIN,
        APPLY
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [NUM_TAG_SIZES_LOG2-1:0] RST_MODE =
        NUM_TAG_SIZES_LOG2'(RESET_TAG_MODE);

    state_t                          state_q;
    state_t                          state_d;
    logic                            pending_q;
    logic [NUM_TAG_SIZES_LOG2-1:0]   pend_mode_q;
    logic [NUM_TAG_SIZES_LOG2-1:0]   tag_mode_q;
    logic                            ack_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [NUM_AXIS_ID-1:0]          rm_q;
    logic                            ctp_q;
    logic                            gate;
    logic                            in_rdy;
    logic                            in_hs;
    logic                            in_last;
    logic                            out_last;
    logic [AXIS_BUS_WIDTH-1:0]       data;
    logic [NUM_BUS_BYTES-1:0]        keep;

    assign data            = axis_in.tdata;
    assign keep            = axis_in.tkeep;
    assign axis_out.tdata  = data;
    assign axis_out.tkeep  = keep;
    assign axis_out.tlast  = axis_in.tlast;
    assign axis_out.tvalid = axis_in.tvalid & gate;
    assign in_rdy          = axis_out.tready & gate;
    assign axis_in.tready  = in_rdy;

    assign in_hs    = axis_in.tvalid & in_rdy;
    assign in_last  = in_hs & axis_in.tlast;
    assign out_last = det_out_tvalid & det_out_tready & det_out_tlast;

    assign route_mask_out      = (state_q == IDLE) ? route_mask_in : rm_q;
    assign cus_tag_present_out = (state_q == IDLE) ? cus_tag_present_in : ctp_q;

    assign cfg_ack        = ack_q;
    assign cfg_busy       = pending_q;
    assign tag_mode       = tag_mode_q;
    assign inflight_count = cnt_q;

    // Next state and input gate; SOP in IDLE wins over entering DRAIN
    always_comb begin
        state_d = state_q;
        gate    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gate = !pending_q && (cnt_q < MAX_CNT);
                if (in_hs) begin
                    state_d = axis_in.tlast ? IDLE : PKT;
                end else if (pending_q) begin
                    state_d = DRAIN;
                end
            end
            PKT: begin
                gate = 1'b1;
                if (in_last) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, config capture/apply, side-channel hold and in-flight count
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            pend_mode_q <= '0;
            tag_mode_q  <= RST_MODE;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            rm_q        <= '0;
            ctp_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_q == APPLY);
            if (state_q == APPLY) begin
                tag_mode_q <= pend_mode_q;
            end
            if (cfg_wr) begin
                pending_q   <= 1'b1;
                pend_mode_q <= cfg_tag_mode;
            end else if (state_q == APPLY) begin
                pending_q <= 1'b0;
            end
            if ((state_q == IDLE) && in_hs) begin
                rm_q  <= route_mask_in;
                ctp_q <= cus_tag_present_in;
            end
            if (in_last && !out_last) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!in_last && out_last && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_detag_cfg_sequencer.sv
// Directed bench for detag_cfg_sequencer with a beat scoreboard.
// Expected output beats are queued at issue and checked by a monitor.
module tb_detag_cfg_sequencer;

    localparam int MAXF = 3;
    localparam int CW   = $clog2(MAXF + 1);

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [15:0] rm;
        logic        ctp;
        logic [1:0]  tm;
    } exp_t;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [15:0]   rm_in = '0;
    logic          ctp_in = 1'b0;
    logic [15:0]   rm_out;
    logic          ctp_out;
    logic          det_v = 1'b0;
    logic          det_r = 1'b0;
    logic          det_l = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic          cfg_wr = 1'b0;
    logic          cfg_ack;
    logic          cfg_busy;
    logic [1:0]    tag_mode;
    logic [CW-1:0] infl;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    detag_cfg_sequencer_if #(.AXIS_BUS_WIDTH(64)) ain ();
    detag_cfg_sequencer_if #(.AXIS_BUS_WIDTH(64)) aout ();

    detag_cfg_sequencer #(
        .AXIS_BUS_WIDTH     (64),
        .AXIS_ID_WIDTH      (4),
        .NUM_TAG_SIZES_LOG2 (2),
        .MAX_INFLIGHT       (MAXF),
        .RESET_TAG_MODE     (0)
    ) dut (
        .aclk                (clk),
        .aresetn             (aresetn),
        .axis_in             (ain),
        .axis_out            (aout),
        .route_mask_in       (rm_in),
        .cus_tag_present_in  (ctp_in),
        .route_mask_out      (rm_out),
        .cus_tag_present_out (ctp_out),
        .det_out_tvalid      (det_v),
        .det_out_tready      (det_r),
        .det_out_tlast       (det_l),
        .cfg_tag_mode        (cfg_mode),
        .cfg_wr              (cfg_wr),
        .cfg_ack             (cfg_ack),
        .cfg_busy            (cfg_busy),
        .tag_mode            (tag_mode),
        .inflight_count      (infl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted output beat must match the queue head
    always @(negedge clk) begin
        exp_t e;
        if (aout.tvalid && aout.tready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%0h required=none",
                         aout.tdata);
            end else begin
                e = q.pop_front();
                chk("out_data", aout.tdata, e.data);
                chk("out_keep", 64'(aout.tkeep), 64'(e.keep));
                chk("out_last", 64'(aout.tlast), 64'(e.last));
                chk("out_rmask", 64'(rm_out), 64'(e.rm));
                chk("out_ctp", 64'(ctp_out), 64'(e.ctp));
                chk("out_tagmode", 64'(tag_mode), 64'(e.tm));
            end
        end
    end

    task automatic beat_full(input logic [63:0] d, input logic [7:0] k,
                             input logic l, input logic [15:0] rm,
                             input logic ctp, input logic [15:0] erm,
                             input logic ectp, input logic [1:0] etm,
                             input int limit, input logic wr,
                             input logic [1:0] wv);
        int   n;
        logic ok;
        q.push_back('{data: d, keep: k, last: l, rm: erm, ctp: ectp,
                      tm: etm});
        ain.tdata  = d;
        ain.tkeep  = k;
        ain.tlast  = l;
        ain.tvalid = 1'b1;
        rm_in      = rm;
        ctp_in     = ctp;
        cfg_wr     = wr;
        cfg_mode   = wv;
        n          = 0;
        checks++;
        forever begin
            @(negedge clk);
            ok = ain.tready;
            @(posedge clk);
            #1;
            cfg_wr = 1'b0;
            if (ok) break;
            n++;
            if (n > limit) begin
                errors++;
                $display("FAIL beat_stall actual=%0d required<=%0d", n, limit);
                break;
            end
        end
        ain.tvalid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] k,
                        input logic l, input logic [15:0] rm,
                        input logic ctp, input logic [1:0] etm,
                        input int limit);
        beat_full(d, k, l, rm, ctp, rm, ctp, etm, limit, 1'b0, 2'd0);
    endtask

    task automatic outlast();
        det_v = 1'b1;
        det_r = 1'b1;
        det_l = 1'b1;
        @(posedge clk);
        #1;
        det_v = 1'b0;
        det_r = 1'b0;
        det_l = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] v);
        cfg_mode = v;
        cfg_wr   = 1'b1;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        ain.tdata   = '0;
        ain.tkeep   = '0;
        ain.tlast   = 1'b0;
        ain.tvalid  = 1'b0;
        aout.tready = 1'b1;

        idle(3);
        chk("rst_tagmode", 64'(tag_mode), 0);
        chk("rst_busy", 64'(cfg_busy), 0);
        chk("rst_ack", 64'(cfg_ack), 0);
        chk("rst_infl", 64'(infl), 0);
        aresetn = 1'b1;
        #1;
        chk("rst_tready", 64'(ain.tready), 1);

        // three 4-beat packets, no config
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                beat({48'hA5A5_0000_0000, 8'(p), 8'(b)},
                     (b == 3) ? 8'h0F : 8'hFF, b == 3,
                     16'(1 << p), p[0], 2'd0, 0);
            end
            chk("t1_infl", 64'(infl), 64'(p + 1));
        end
        for (int i = 0; i < 3; i++) begin
            outlast();
            chk("t1_drain", 64'(infl), 64'(2 - i));
        end

        // cfg_wr on beat 2 of a 5-beat packet
        for (int b = 0; b < 5; b++) begin
            beat_full({48'hB0B0_0000_0000, 8'd3, 8'(b)}, 8'hFF, b == 4,
                      16'h0008, 1'b0, 16'h0008, 1'b0, 2'd0, 0,
                      b == 1, 2'd2);
        end
        chk("t2_busy", 64'(cfg_busy), 1);
        chk("t2_infl", 64'(infl), 1);
        fork
            beat(64'hC0C0_0000_0000_0004, 8'h3F, 1'b1, 16'h0010, 1'b1,
                 2'd2, 20);
            begin
                @(negedge clk);
                chk("t2_sop_held", 64'(ain.tready), 0);
                @(posedge clk);
                #1;
                outlast();
                idle(1);
                chk("t2_ack_early", 64'(cfg_ack), 0);
                chk("t2_tm_old", 64'(tag_mode), 0);
                idle(1);
                chk("t2_ack", 64'(cfg_ack), 1);
                chk("t2_tm_new", 64'(tag_mode), 2);
                chk("t2_busy_clr", 64'(cfg_busy), 0);
                idle(1);
                chk("t2_ack_pulse", 64'(cfg_ack), 0);
            end
        join
        chk("t2_infl_after", 64'(infl), 1);

        // two writes back to back while DRAIN waits on two packets
        beat(64'hD000_0000_0000_0500, 8'hFF, 1'b0, 16'h0020, 1'b0, 2'd2, 0);
        beat(64'hD000_0000_0000_0501, 8'h01, 1'b1, 16'h0020, 1'b0, 2'd2, 0);
        cfg(2'd1);
        cfg(2'd3);
        idle(3);
        chk("t3_infl", 64'(infl), 2);
        chk("t3_tm_hold", 64'(tag_mode), 2);
        chk("t3_busy", 64'(cfg_busy), 1);
        outlast();
        outlast();
        acks = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            acks += int'(cfg_ack);
        end
        chk("t3_one_ack", 64'(acks), 1);
        chk("t3_tm_final", 64'(tag_mode), 3);
        chk("t3_busy_clr", 64'(cfg_busy), 0);

        // in-flight limit; single-beat packets each carry own mask
        for (int p = 0; p < 3; p++) begin
            beat({48'hE000_0000_0000, 8'd6, 8'(p)}, 8'h0F, 1'b1,
                 16'(16'h0100 << p), p[0], 2'd3, 0);
        end
        chk("t4_infl_max", 64'(infl), 3);
        fork
            beat(64'hE000_0000_0000_0900, 8'h0F, 1'b1, 16'h8000, 1'b1,
                 2'd3, 20);
            begin
                @(negedge clk);
                chk("t4_held_a", 64'(ain.tready), 0);
                @(posedge clk);
                #1;
                @(negedge clk);
                chk("t4_held_b", 64'(ain.tready), 0);
                @(posedge clk);
                #1;
                outlast();
                @(negedge clk);
                chk("t4_release", 64'(ain.tready), 1);
            end
        join
        chk("t4_infl_back", 64'(infl), 3);
        repeat (3) outlast();
        chk("t4_infl_zero", 64'(infl), 0);
        outlast();
        chk("t4_sat_zero", 64'(infl), 0);

        // apply mode 1 with nothing in flight
        cfg(2'd1);
        idle(4);
        chk("t5_tm1", 64'(tag_mode), 1);

        // side channels frozen at SOP
        beat_full(64'hF000_0000_0000_0000, 8'hFF, 1'b0, 16'h0005, 1'b1,
                  16'h0005, 1'b1, 2'd1, 0, 1'b0, 2'd0);
        beat_full(64'hF000_0000_0000_0001, 8'hFF, 1'b0, 16'h0005, 1'b1,
                  16'h0005, 1'b1, 2'd1, 0, 1'b0, 2'd0);
        beat_full(64'hF000_0000_0000_0002, 8'hFF, 1'b0, 16'h00A0, 1'b0,
                  16'h0005, 1'b1, 2'd1, 0, 1'b0, 2'd0);
        beat_full(64'hF000_0000_0000_0003, 8'h07, 1'b1, 16'h00A0, 1'b0,
                  16'h0005, 1'b1, 2'd1, 0, 1'b0, 2'd0);
        beat(64'hF100_0000_0000_0000, 8'h03, 1'b1, 16'h00A0, 1'b0,
             2'd1, 0);
        chk("t5_infl", 64'(infl), 2);

        // reset while draining
        cfg(2'd2);
        idle(2);
        chk("t6_busy", 64'(cfg_busy), 1);
        chk("t6_tm", 64'(tag_mode), 1);
        aresetn = 1'b0;
        idle(1);
        aresetn = 1'b1;
        #1;
        chk("t6_infl", 64'(infl), 0);
        chk("t6_tm_rst", 64'(tag_mode), 0);
        chk("t6_busy_rst", 64'(cfg_busy), 0);
        chk("t6_tready", 64'(ain.tready), 1);
        beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 16'h0042, 1'b1,
             2'd0, 0);
        chk("t6_infl_post", 64'(infl), 1);

        idle(2);
        chk("queue_empty", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
